vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8: RAM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 63: port-B wait limit in cycles (used only with the starvation guard).
REQ-004 SHALL have port Clk, input, 1: single clock for all logic, rising edge.
REQ-005 SHALL have port Reset_n, input, 1: asynchronous reset, active-low.
REQ-006 SHALL have port vid_active, input, 1: 1 during the active display region.
REQ-007 SHALL have port a_req, input, 1: pixel-fetch read request.
REQ-008 SHALL have port a_addr, input, ADDR_W: pixel-fetch address.
REQ-009 SHALL have port a_gnt, output, 1: A is served this cycle.
REQ-010 SHALL have ports a_rvalid (output, 1) and a_rdata (output, DATA_W): A read data.
REQ-011 SHALL have ports b_req, b_we (input, 1), b_addr (input, ADDR_W) and b_wdata (input, DATA_W): game-logic access.
REQ-012 SHALL have ports b_ack (output, 1; B request accepted), b_pending (output, 1; buffer full), b_rvalid (output, 1) and b_rdata (output, DATA_W).
REQ-013 SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W): single-port RAM with 1-cycle read latency.

Function
REQ-014 SHALL issue at most one RAM access per cycle.
REQ-015 SHALL accept a B request into a one-entry buffer: b_ack = b_req AND NOT b_pending (combinational); capture occurs on that edge; b_pending = 1 from the next cycle.
REQ-016 SHALL NOT refill the buffer in the cycle it is being served; a new b_ack is possible no earlier than the cycle after service.
REQ-017 SHALL give A priority: when a_req = 1 and no forced B slot, a_gnt = 1 combinationally, mem_addr = a_addr, mem_we = 0.
REQ-018 SHALL serve the buffered B entry in any cycle where a_req = 0 and b_pending = 1; a buffered B entry is never served in its capture cycle.
REQ-019 SHALL, for a B write, drive mem_we = 1 and mem_wdata = buffered data for exactly one cycle, and assert no b_rvalid.
REQ-020 SHALL assert a_rvalid (or b_rvalid for a B read) for one cycle, exactly one cycle after the serving cycle, with a_rdata/b_rdata = mem_rdata in that cycle.
REQ-021 SHALL track the last-served port in a registered state: IDLE, SERVE_A, SERVE_B. Next state is SERVE_A when A is served, SERVE_B when B is served, else IDLE. This state routes the rvalid signals.
REQ-022 SHALL drive mem_we = 0 and hold mem_addr at its previous value in IDLE cycles.
REQ-023 SHALL allow simultaneous a_req and b_req: A is served and B is accepted into the buffer in the same cycle.

Reset
REQ-024 SHALL, while Reset_n = 0, force the following regardless of Clk: state IDLE, buffer empty, starvation counter 0, and a_gnt, a_rvalid, b_ack, b_pending, b_rvalid and mem_we all 0; mem_addr, mem_wdata, a_rdata and b_rdata 0.
REQ-025 SHALL, when reset is asserted mid-transaction, discard any pending B entry and produce no rvalid for an access served before reset.

Configuration
REQ-026 SHALL compile a starvation guard only when the macro VRAM_ARB_STARVE_GUARD_EN is defined.
REQ-027 With VRAM_ARB_STARVE_GUARD_EN defined, counter behaviour SHALL be:
- increments each cycle b_pending = 1 and B is not served;
- clears when B is served;
- saturates at STARVE_MAX.
REQ-028 With VRAM_ARB_STARVE_GUARD_EN defined, when the counter equals STARVE_MAX, B SHALL be served in that cycle even if a_req = 1, with a_gnt = 0.
REQ-029 With VRAM_ARB_STARVE_GUARD_EN undefined, B SHALL be served only when a_req = 0, and no counter SHALL exist.

Verification
REQ-030 The bench SHALL cover: a_req = 1 with a_addr = 0x123 for one cycle, mem_rdata = 0x5A next cycle -> a_gnt = 1 that cycle, a_rvalid = 1 and a_rdata = 0x5A next cycle.
REQ-031 The bench SHALL cover: b_req = 1, b_we = 1, b_addr = 0x010, b_wdata = 0xC3 with a_req = 0 -> b_ack same cycle, then one cycle of mem_we = 1, mem_addr = 0x010, mem_wdata = 0xC3, b_pending = 0 after, no b_rvalid.
REQ-032 The bench SHALL cover: a_req and b_req (read, 0x020) both 1 for one cycle, then a_req = 1 for 3 more cycles -> A granted all 4 cycles, B read served in cycle 5, b_rvalid in cycle 6.
REQ-033 The bench SHALL cover, guard enabled with STARVE_MAX = 4: a_req held 1, B write buffered -> B forced at the wait-count-4 cycle with a_gnt = 0 there, A resumes next cycle.
REQ-034 The bench SHALL cover: b_req held 1 continuously -> b_ack pulses at most every other cycle, never while b_pending = 1.
REQ-035 The bench SHALL cover: Reset_n dropped while b_pending = 1 and a_rvalid is due next cycle -> all outputs 0 immediately, and no rvalid or mem_we after release.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter, pixel fetch (A) has priority over buffered game-logic access (B)
// Ports: Clk/Reset_n (async active-low), vid_active (display region flag, informational)
//        A: a_req/a_addr in, a_gnt/a_rvalid/a_rdata out
//        B: b_req/b_we/b_addr/b_wdata in, b_ack/b_pending/b_rvalid/b_rdata out
//        RAM: mem_addr/mem_we/mem_wdata out, mem_rdata in (1-cycle read latency)
// Option: VRAM_ARB_STARVE_GUARD_EN adds a B starvation guard limited by STARVE_MAX
module vram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 63
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vid_active,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_pending,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;
    state_t            state;
    logic              b_pending_q;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic              b_rd_q;
    logic [ADDR_W-1:0] last_addr;
    logic              force_b;
    logic              serve_b;
    logic              unused_ok;
    assign unused_ok = vid_active ^ (STARVE_MAX != 0);
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 2);
    logic [CW-1:0] starve_cnt;
    assign force_b = b_pending_q && starve_cnt == CW'(STARVE_MAX);
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n)
            starve_cnt <= '0;
        else if (serve_b)
            starve_cnt <= '0;
        else if (b_pending_q && starve_cnt != CW'(STARVE_MAX))
            starve_cnt <= starve_cnt + CW'(1);
`else
    assign force_b = 1'b0;
`endif
    // Reset_n gates the combinational handshakes so they read 0 during reset
    assign a_gnt     = Reset_n & a_req & ~force_b;
    assign serve_b   = b_pending_q & (~a_req | force_b);
    assign b_ack     = Reset_n & b_req & ~b_pending_q;
    assign b_pending = b_pending_q;
    assign mem_addr  = a_gnt ? a_addr : serve_b ? buf_addr : last_addr;
    assign mem_we    = serve_b & buf_we;
    assign mem_wdata = buf_wdata;
    assign a_rvalid  = state == SERVE_A;
    assign b_rvalid  = state == SERVE_B && b_rd_q;
    assign a_rdata   = a_rvalid ? mem_rdata : '0;
    assign b_rdata   = b_rvalid ? mem_rdata : '0;
    // b_ack and serve_b are exclusive: capture needs an empty buffer, service a full one
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            b_pending_q <= 1'b0;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            b_rd_q      <= 1'b0;
            last_addr   <= '0;
        end else begin
            state     <= a_gnt ? SERVE_A : serve_b ? SERVE_B : IDLE;
            b_rd_q    <= serve_b & ~buf_we;
            last_addr <= mem_addr;
            if (b_ack) begin
                b_pending_q <= 1'b1;
                buf_we      <= b_we;
                buf_addr    <= b_addr;
                buf_wdata   <= b_wdata;
            end else if (serve_b) begin
                b_pending_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vectors, corner sequences and random traffic against a behavioural model
module tb_vram_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int SM = 4;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          vid_active = 1'b0;
    logic          a_req = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic          a_gnt, a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0;
    logic          b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_ack, b_pending, b_rvalid;
    logic [DW-1:0] b_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .vid_active(vid_active),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_pending(b_pending), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    always #5 Clk = ~Clk;
    int checks = 0;
    int errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } bent_t;
    bent_t         bq[$];
    int            wait_n;
    logic          prev_a, prev_brd;
    logic [AW-1:0] last_addr;
    task automatic model_reset();
        bq.delete();
        wait_n = 0;
        prev_a = 1'b0;
        prev_brd = 1'b0;
        last_addr = '0;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_a_gnt"}, a_gnt, 0);
        chk({tag, "_a_rvalid"}, a_rvalid, 0);
        chk({tag, "_a_rdata"}, a_rdata, 0);
        chk({tag, "_b_ack"}, b_ack, 0);
        chk({tag, "_b_pending"}, b_pending, 0);
        chk({tag, "_b_rvalid"}, b_rvalid, 0);
        chk({tag, "_b_rdata"}, b_rdata, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask
    task automatic step(input logic ar, input logic [AW-1:0] aa, input logic br, input logic bw,
                        input logic [AW-1:0] ba, input logic [DW-1:0] bd, input logic [DW-1:0] rd);
        bit            pend, frc, g, sb, ack;
        bent_t         hd;
        logic [AW-1:0] ea;
        @(negedge Clk);
        a_req = ar; a_addr = aa; b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; mem_rdata = rd;
        #1;
        pend = bq.size() != 0;
        if (pend) hd = bq[0];
        else hd = '{1'b0, '0, '0};
        frc = GUARD && pend && wait_n == SM;
        g = ar && !frc;
        sb = pend && (!ar || frc);
        ack = br && !pend;
        ea = g ? aa : sb ? hd.addr : last_addr;
        chk("m_a_gnt", a_gnt, g);
        chk("m_b_ack", b_ack, ack);
        chk("m_b_pending", b_pending, pend);
        chk("m_mem_we", mem_we, sb && hd.we);
        chk("m_mem_addr", mem_addr, ea);
        chk("m_a_rvalid", a_rvalid, prev_a);
        chk("m_b_rvalid", b_rvalid, prev_brd);
        if (prev_a) chk("m_a_rdata", a_rdata, rd);
        if (prev_brd) chk("m_b_rdata", b_rdata, rd);
        if (sb && hd.we) chk("m_mem_wdata", mem_wdata, hd.data);
        prev_a = g;
        prev_brd = sb && !hd.we;
        if (sb) begin
            void'(bq.pop_front());
            wait_n = 0;
        end else if (pend && wait_n < SM) begin
            wait_n++;
        end
        if (ack) bq.push_back('{bw, ba, bd});
        last_addr = ea;
    endtask
    typedef struct {
        logic          ar;
        logic [AW-1:0] aa;
        logic          br, bw;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd, rd;
        logic          g, ack, pend, we, arv, brv;
        logic [AW-1:0] ma;
    } vec_t;
    vec_t tbl[12];
    initial begin
        int acks;
        tbl[0]  = '{1'b1, 12'h123, 1'b0, 1'b0, 12'h000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123};
        tbl[1]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123};
        tbl[2]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 8'hC3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123};
        tbl[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h010};
        tbl[4]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010};
        tbl[5]  = '{1'b1, 12'h0AA, 1'b1, 1'b0, 12'h020, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AA};
        tbl[6]  = '{1'b1, 12'h0AB, 1'b0, 1'b0, 12'h000, 8'h00, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0AB};
        tbl[7]  = '{1'b1, 12'h0AC, 1'b0, 1'b0, 12'h000, 8'h00, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0AC};
        tbl[8]  = '{1'b1, 12'h0AD, 1'b0, 1'b0, 12'h000, 8'h00, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0AD};
        tbl[9]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h020};
        tbl[10] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h020};
        tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h020};
        a_req = 1'b1; b_req = 1'b1; a_addr = 12'hFFF; mem_rdata = 8'hFF;
        #12;
        chk_zero("rst");
        @(negedge Clk);
        a_req = 1'b0; b_req = 1'b0; a_addr = '0; mem_rdata = '0;
        Reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].ar, tbl[i].aa, tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd, tbl[i].rd);
            chk($sformatf("v%0d_a_gnt", i), a_gnt, tbl[i].g);
            chk($sformatf("v%0d_b_ack", i), b_ack, tbl[i].ack);
            chk($sformatf("v%0d_b_pending", i), b_pending, tbl[i].pend);
            chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].we);
            chk($sformatf("v%0d_a_rvalid", i), a_rvalid, tbl[i].arv);
            chk($sformatf("v%0d_b_rvalid", i), b_rvalid, tbl[i].brv);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].ma);
            if (i == 1) chk("v1_a_rdata", a_rdata, 8'h5A);
            if (i == 3) chk("v3_mem_wdata", mem_wdata, 8'hC3);
            if (i == 10) chk("v10_b_rdata", b_rdata, 8'h66);
        end
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, AW'(12'h100 + i), '0, DW'(i));
            chk("hold_ack_while_pending", b_ack & b_pending, 0);
            acks += int'(b_ack);
        end
        chk("hold_ack_count", acks, 4);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
`ifdef VRAM_ARB_STARVE_GUARD_EN
        step(1'b1, 12'h200, 1'b1, 1'b1, 12'h030, 8'h99, '0);
        chk("starve_c0_gnt", a_gnt, 1);
        chk("starve_c0_ack", b_ack, 1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, AW'(12'h200 + k), 1'b0, 1'b0, '0, '0, '0);
            chk($sformatf("starve_c%0d_gnt", k), a_gnt, 1);
            chk($sformatf("starve_c%0d_we", k), mem_we, 0);
        end
        step(1'b1, 12'h205, 1'b0, 1'b0, '0, '0, '0);
        chk("starve_force_gnt", a_gnt, 0);
        chk("starve_force_we", mem_we, 1);
        chk("starve_force_addr", mem_addr, 12'h030);
        chk("starve_force_wdata", mem_wdata, 8'h99);
        step(1'b1, 12'h206, 1'b0, 1'b0, '0, '0, '0);
        chk("starve_resume_gnt", a_gnt, 1);
        chk("starve_resume_pend", b_pending, 0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
`endif
        step(1'b0, '0, 1'b1, 1'b0, 12'h040, '0, '0);
        @(negedge Clk);
        a_req = 1'b1; a_addr = 12'h050; b_req = 1'b0; mem_rdata = 8'hA5;
        #1;
        chk("rst_mid_pend", b_pending, 1);
        chk("rst_mid_gnt", a_gnt, 1);
        Reset_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge Clk);
        chk_zero("rst_hold");
        a_req = 1'b0; a_addr = '0; mem_rdata = '0;
        Reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, '0, '0, 8'h5A);
            chk("rst_after_a_rvalid", a_rvalid, 0);
            chk("rst_after_mem_we", mem_we, 0);
            chk("rst_after_b_pending", b_pending, 0);
        end
        for (int i = 0; i < 400; i++) begin
            vid_active = 1'($urandom);
            step($urandom_range(0, 99) < 45, AW'($urandom), $urandom_range(0, 99) < 50, 1'($urandom),
                 AW'($urandom), DW'($urandom), DW'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
